// File: rtl/pll_lock_sequencer.sv
// Supervises the VGA pixel-clock PLL: pulses its reset, waits for lock, qualifies
// lock stability, then releases the VGA-domain reset. Retries on timeout, fails sticky.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 10,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16,
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic            refclk,
  input  logic            rst,
  input  logic            locked,
  input  logic            relock_req,
  output logic            pll_rst,
  output logic            sys_rst_out,
  output logic            ready,
  output logic            fail,
  output logic [RC_W-1:0] retry_count,
  output logic [7:0]      lost_lock_count,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX    = RC_W'(MAX_RETRIES);

  state_t           cur_state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic [RC_W-1:0]  retry_next;
  logic [7:0]       lost_next;
  logic             locked_meta;
  logic             locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= locked;
      locked_s    <= locked_meta;
    end
  end

  // relock_req takes priority in the sequencing states; in RUN a lock loss wins
  // so it is always counted, and relock then adds nothing beyond the same restart.
  always_comb begin
    next_state = cur_state;
    timer_next = timer + CNT_W'(1);
    retry_next = retry_count;
    lost_next  = lost_lock_count;
    case (cur_state)
      RESET_PLL: begin
        if (relock_req) begin
          timer_next = '0;
        end else if (timer == RST_LAST) begin
          next_state = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (relock_req) begin
          next_state = RESET_PLL;
        end else if (locked_s) begin
          next_state = STABILIZE;
        end else if (timer == TIMEOUT_LAST) begin
          if (retry_count == RETRY_MAX) begin
            next_state = FAIL;
          end else begin
            retry_next = retry_count + RC_W'(1);
            next_state = RESET_PLL;
          end
        end
      end
      STABILIZE: begin
        if (relock_req) begin
          next_state = RESET_PLL;
        end else if (!locked_s) begin
          next_state = WAIT_LOCK;
        end else if (timer == STABLE_LAST) begin
          next_state = RUN;
          retry_next = '0;
        end
      end
      RUN: begin
        timer_next = '0;
        if (!locked_s) begin
          if (lost_lock_count != 8'hFF) begin
            lost_next = lost_lock_count + 8'd1;
          end
          next_state = RESET_PLL;
        end else if (relock_req) begin
          next_state = RESET_PLL;
        end
      end
      FAIL: begin
        timer_next = '0;
        if (relock_req) begin
          next_state = RESET_PLL;
          retry_next = '0;
        end
      end
      default: begin
        next_state = RESET_PLL;
        timer_next = '0;
      end
    endcase
    if (next_state != cur_state) begin
      timer_next = '0;
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      cur_state       <= RESET_PLL;
      timer           <= '0;
      retry_count     <= '0;
      lost_lock_count <= 8'd0;
      pll_rst         <= 1'b1;
      sys_rst_out     <= 1'b1;
      ready           <= 1'b0;
      fail            <= 1'b0;
    end else begin
      cur_state       <= next_state;
      timer           <= timer_next;
      retry_count     <= retry_next;
      lost_lock_count <= lost_next;
      pll_rst         <= (next_state == RESET_PLL);
      sys_rst_out     <= (next_state != RUN);
      ready           <= (next_state == RUN);
      fail            <= (next_state == FAIL);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed and randomized bench for pll_lock_sequencer, checked against a
// phase/deadline reference model of the lock sequence.
module tb_pll_lock_sequencer;

  localparam int RST_PULSE_CYCLES    = 4;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int LOCK_TIMEOUT_CYCLES = 20;
  localparam int MAX_RETRIES         = 2;
  localparam int CNT_W               = 16;

  localparam int M_RESET = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAIL = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst_out;
  logic       ready;
  logic       fail;
  logic [1:0] retry_count;
  logic [7:0] lost_lock_count;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  // Reference model: phase plus the cycle number at which the phase began.
  int m_state = M_RESET;
  int m_cyc = 0;
  int m_start = 0;
  int m_retries = 0;
  int m_losses = 0;
  bit m_meta = 1'b0;
  bit m_ls = 1'b0;

  int n;
  int hi;
  int waits;
  logic prev_sys;
  logic lk;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES(RST_PULSE_CYCLES),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
    .MAX_RETRIES(MAX_RETRIES),
    .CNT_W(CNT_W)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .locked(locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .sys_rst_out(sys_rst_out),
    .ready(ready),
    .fail(fail),
    .retry_count(retry_count),
    .lost_lock_count(lost_lock_count),
    .state(state)
  );

  always #5 refclk = ~refclk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic enterPhase(input int s);
    m_state = s;
    m_start = m_cyc;
  endtask

  task automatic modelStep();
    bit ls_now;
    int age;
    ls_now = m_ls;
    m_cyc++;
    age = m_cyc - m_start;
    if (rst) begin
      enterPhase(M_RESET);
      m_retries = 0;
      m_losses = 0;
      m_meta = 1'b0;
      m_ls = 1'b0;
      return;
    end
    case (m_state)
      M_RESET: begin
        if (relock_req) m_start = m_cyc;
        else if (age == RST_PULSE_CYCLES) enterPhase(M_WAIT);
      end
      M_WAIT: begin
        if (relock_req) enterPhase(M_RESET);
        else if (ls_now) enterPhase(M_STAB);
        else if (age == LOCK_TIMEOUT_CYCLES) begin
          if (m_retries == MAX_RETRIES) enterPhase(M_FAIL);
          else begin
            m_retries++;
            enterPhase(M_RESET);
          end
        end
      end
      M_STAB: begin
        if (relock_req) enterPhase(M_RESET);
        else if (!ls_now) enterPhase(M_WAIT);
        else if (age == LOCK_STABLE_CYCLES) begin
          m_retries = 0;
          enterPhase(M_RUN);
        end
      end
      M_RUN: begin
        if (!ls_now) begin
          m_losses = (m_losses < 255) ? m_losses + 1 : 255;
          enterPhase(M_RESET);
        end else if (relock_req) enterPhase(M_RESET);
      end
      default: begin
        if (relock_req) begin
          m_retries = 0;
          enterPhase(M_RESET);
        end
      end
    endcase
    m_ls = m_meta;
    m_meta = locked;
  endtask

  task automatic checkOutput();
    checkValue("state", state, m_state);
    checkValue("pll_rst", pll_rst, (m_state == M_RESET));
    checkValue("sys_rst_out", sys_rst_out, (m_state != M_RUN));
    checkValue("ready", ready, (m_state == M_RUN));
    checkValue("fail", fail, (m_state == M_FAIL));
    checkValue("retry_count", retry_count, m_retries);
    checkValue("lost_lock_count", lost_lock_count, m_losses);
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic q);
    rst = r;
    locked = l;
    relock_req = q;
    @(posedge refclk);
    modelStep();
    @(negedge refclk);
    checkOutput();
  endtask

  task automatic checkResetValues(input string tag);
    checkValue({tag, "_state"}, state, 0);
    checkValue({tag, "_pll_rst"}, pll_rst, 1);
    checkValue({tag, "_sys_rst_out"}, sys_rst_out, 1);
    checkValue({tag, "_ready"}, ready, 0);
    checkValue({tag, "_fail"}, fail, 0);
    checkValue({tag, "_retry_count"}, retry_count, 0);
    checkValue({tag, "_lost_lock_count"}, lost_lock_count, 0);
  endtask

  task automatic runUntilReady(input string tag);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
    checkValue({tag, "_reached_ready"}, ready, 1);
  endtask

  initial begin
    $display("[TB] starting pll_lock_sequencer bench");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkResetValues("reset");

    // Test 1: pulse width and lock qualification latency
    hi = (pll_rst === 1'b1) ? 1 : 0;
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
      if (pll_rst === 1'b1) hi++;
    end while (pll_rst === 1'b1 && n < 50);
    checkValue("t1_pll_rst_width", hi, RST_PULSE_CYCLES);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    prev_sys = sys_rst_out;
    while (ready !== 1'b1 && n < 100) begin
      prev_sys = sys_rst_out;
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
    checkValue("t1_ready_latency", n, LOCK_STABLE_CYCLES + 2);
    checkValue("t1_sys_rst_before_ready", prev_sys, 1);
    checkValue("t1_sys_rst_with_ready", sys_rst_out, 0);

    // Test 2: retries exhausted, FAIL is sticky, relock leaves it
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkValue("t2_relock_from_run", state, 0);
    n = 0;
    waits = 0;
    while (fail !== 1'b1 && n < 300) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
      if (state === 3'd1) waits++;
    end
    checkValue("t2_cycles_to_fail", n, (MAX_RETRIES + 1) * (RST_PULSE_CYCLES + LOCK_TIMEOUT_CYCLES));
    checkValue("t2_wait_lock_cycles", waits, (MAX_RETRIES + 1) * LOCK_TIMEOUT_CYCLES);
    checkValue("t2_fail_state", state, 4);
    checkValue("t2_fail_retry_count", retry_count, MAX_RETRIES);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("t2_fail_sticky", state, 4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkValue("t2_exit_state", state, 0);
    checkValue("t2_exit_fail", fail, 0);
    checkValue("t2_exit_retry_count", retry_count, 0);

    // Test 3: lock drop during STABILIZE forces a full requalification
    n = 0;
    while (state !== 3'd1 && n < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    n = 0;
    while (state !== 3'd2 && n < 20) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
    checkValue("t3_in_stabilize", state, 2);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("t3_back_to_wait", state, 1);
    checkValue("t3_retry_unchanged", retry_count, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
    checkValue("t3_requalify_latency", n, LOCK_STABLE_CYCLES + 2);

    // Test 4 (first loss): outputs respond two cycles after the pin drops
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("t4_ready_edge0", ready, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("t4_ready_edge1", ready, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("t4_ready_edge2", ready, 0);
    checkValue("t4_sys_rst_edge2", sys_rst_out, 1);
    checkValue("t4_pll_rst_edge2", pll_rst, 1);
    checkValue("t4_lost_one", lost_lock_count, 1);

    // Test 5: loss and relock in the same cycle give one count, one sequence
    runUntilReady("t5");
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkValue("t5_state", state, 0);
    checkValue("t5_lost_plus_one", lost_lock_count, 2);
    hi = (pll_rst === 1'b1) ? 1 : 0;
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
      if (pll_rst === 1'b1) hi++;
    end while (pll_rst === 1'b1 && n < 50);
    checkValue("t5_single_pulse", hi, RST_PULSE_CYCLES);
    runUntilReady("t5b");
    checkValue("t5_lost_after_run", lost_lock_count, 2);

    // Test 4 (saturation): 300 more lock losses
    for (int i = 0; i < 300; i++) begin
      runUntilReady("t4_loop");
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkValue("t4_lost_saturated", lost_lock_count, 255);

    // Test 6: synchronous reset mid-STABILIZE and mid-RUN
    n = 0;
    while (state !== 3'd2 && n < 30) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
    checkValue("t6_in_stabilize", state, 2);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkResetValues("t6_stab_rst");
    runUntilReady("t6");
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkResetValues("t6_run_rst");

    // Randomized traffic: lively lock first, then mostly-absent lock
    lk = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (i < 400) begin
        if ($urandom_range(0, 11) == 0) lk = ~lk;
      end else begin
        lk = ($urandom_range(0, 39) == 0);
      end
      applyStimulus(($urandom_range(0, 149) == 0), lk, ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Supervises the VGA pixel-clock PLL from the 50 MHz reference domain. Drives the PLL reset, waits for lock, and qualifies lock as stable before releasing the downstream VGA-domain reset. It retries on lock timeout, enters a sticky failure state after too many retries, and re-sequences on lock loss or on a software relock request.

Parameters:
RST_PULSE_CYCLES, 10, refclk cycles that pll_rst is held high per reset attempt (≥1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before ready (≥1)
LOCK_TIMEOUT_CYCLES, 50000, refclk cycles allowed in WAIT_LOCK before a retry (≥1, 1 ms at 50 MHz)
MAX_RETRIES, 3, timeouts tolerated before FAIL (≥0)
CNT_W, 16, shared timer width; each cycle-count parameter must be ≤ 2^CNT_W

Ports:
refclk  in  1  50 MHz reference clock; the only clock
rst  in  1  synchronous, active-high reset
locked  in  1  PLL lock, asynchronous to refclk
relock_req  in  1  single-cycle request to re-sequence the PLL
pll_rst  out  1  reset to the PLL, registered
sys_rst_out  out  1  hold-reset for the VGA datapath, registered, high until ready
ready  out  1  PLL locked and qualified
fail  out  1  retry budget exhausted, sticky
retry_count  out  $clog2(MAX_RETRIES+1) (min 1)  timeouts in the current sequence
lost_lock_count  out  8  lock losses seen in RUN, saturating at 255
state  out  3  current state encoding: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4

Behaviour:
- Interface: one clock, refclk. Reset rst is synchronous and active-high.
- Reset values: state=RESET_PLL, timer=0, pll_rst=1, sys_rst_out=1, ready=0, fail=0, retry_count=0, lost_lock_count=0. rst overrides every other input.
- All outputs are registered and decoded from the next state, so they change on the same edge as state.
- locked passes through a 2-flop synchronizer to give locked_s. The internal latency from the locked pin to locked_s is 2 cycles.
- RESET_PLL:
  - pll_rst=1.
  - The timer counts up from 0.
  - When the timer reaches RST_PULSE_CYCLES-1, go to WAIT_LOCK with timer=0.
  - pll_rst is high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABILIZE with timer=0.
  - Otherwise, when the timer reaches LOCK_TIMEOUT_CYCLES-1:
    - if retry_count==MAX_RETRIES, go to FAIL;
    - else increment retry_count and go to RESET_PLL.
  - Lock takes priority over timeout when both occur in the same cycle.
- STABILIZE:
  - If locked_s=0, return to WAIT_LOCK with timer=0. retry_count is unchanged.
  - When the timer reaches LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN.
  - Timing: ready rises LOCK_STABLE_CYCLES+2 cycles after the edge on which the locked pin is first sampled high. That edge is t; ready is high from edge t+2+LOCK_STABLE_CYCLES.
- RUN:
  - ready=1, sys_rst_out=0, retry_count=0.
  - If locked_s=0, lost_lock_count increments (saturating) and the block goes to RESET_PLL.
  - Else if relock_req=1, go to RESET_PLL.
  - If both occur in the same cycle, the lock loss is counted and a single re-sequence follows.
  - On leaving RUN, ready=0 and sys_rst_out=1 on the same edge.
- FAIL:
  - fail=1, pll_rst=0, sys_rst_out=1, ready=0.
  - locked is ignored.
  - Exit only via rst, or via relock_req, which goes to RESET_PLL with retry_count=0 and fail=0.
- relock_req in RESET_PLL, WAIT_LOCK or STABILIZE restarts RESET_PLL with timer=0. retry_count is unchanged.
- A glitch on locked shorter than one refclk period may be filtered by the synchronizer; no requirement applies to such glitches.
- Timer arithmetic: unsigned CNT_W bits, compared with ==, cleared on every state change; it never wraps in a legal configuration.

Test Plan (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=20, MAX_RETRIES=2):
1. Release rst with locked=0, then assert locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready rises 10 edges after locked is first sampled high; sys_rst_out falls on the same edge.
2. locked held at 0 -> three WAIT_LOCK windows of 20 cycles, separated by 4-cycle pll_rst pulses; retry_count steps 0→1→2; then FAIL with fail=1, state=4. Pulse relock_req -> RESET_PLL, fail=0, retry_count=0.
3. During STABILIZE, drop locked for 3 cycles at timer=5 -> back to WAIT_LOCK with retry_count unchanged; re-assert locked -> a full 8-cycle qualification is needed before ready.
4. In RUN, drop locked -> 2 cycles later ready=0, sys_rst_out=1, pll_rst=1, lost_lock_count=1. Repeat 300 times -> lost_lock_count stays at 255.
5. In RUN, assert relock_req and drop locked so both reach the FSM in the same cycle -> one RESET_PLL sequence, lost_lock_count increments by exactly 1.
6. Assert rst mid-STABILIZE and mid-RUN -> next edge: all outputs at their reset values, state=0.
